// File: rtl/srdl2sv_ahblite_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : srdl2sv_ahblite_burst_if
// Description : AHB-Lite slave port plus register-side (b2r/r2b) handshake
//               bundled as one interface.
//               slave  modport - the bridge: samples AHB controls and the
//                                register response, drives AHB response and
//                                register strobes.
//               master modport - the environment: the AHB master and the
//                                register file together.
// Revision    : 1.0 - initial release
// ============================================================================
interface srdl2sv_ahblite_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // AHB-Lite address/data phase
    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [3:0]              HPROT;
    logic [1:0]              HTRANS;
    logic                    HMASTLOCK;
    logic                    HREADY;
    logic [DATA_WIDTH-1:0]   HWDATA;
    // AHB-Lite slave response
    logic                    HREADYOUT;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;
    // Register side
    logic                    b2r_w_vld;
    logic                    b2r_r_vld;
    logic [ADDR_WIDTH-1:0]   b2r_addr;
    logic [DATA_WIDTH-1:0]   b2r_data;
    logic [DATA_WIDTH/8-1:0] b2r_byte_en;
    logic                    r2b_rdy;
    logic                    r2b_err;
    logic [DATA_WIDTH-1:0]   r2b_data;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HREADY, HWDATA, r2b_rdy, r2b_err, r2b_data,
        output HREADYOUT, HRESP, HRDATA,
        output b2r_w_vld, b2r_r_vld, b2r_addr, b2r_data, b2r_byte_en
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HREADY, HWDATA, r2b_rdy, r2b_err, r2b_data,
        input  HREADYOUT, HRESP, HRDATA,
        input  b2r_w_vld, b2r_r_vld, b2r_addr, b2r_data, b2r_byte_en
    );
endinterface
`default_nettype wire

// File: rtl/srdl2sv_ahblite_burst.sv
`default_nettype none
// ============================================================================
// Module      : srdl2sv_ahblite_burst
// Description : AHB-Lite slave to register-bus bridge with burst checking.
//               Each accepted AHB beat becomes one b2r read/write strobe held
//               until r2b_rdy. Misaligned, oversized and out-of-burst SEQ
//               beats get a two-cycle ERROR response without touching the
//               register side.
// Ports       : HCLK    - clock, rising edge
//               HRESETn - asynchronous active-low reset
//               bus     - slave modport: AHB-Lite controls/response and the
//                         b2r/r2b register handshake
// Revision    : 1.0 - initial release
// ============================================================================
module srdl2sv_ahblite_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input wire HCLK,
    input wire HRESETn,
    srdl2sv_ahblite_burst_if.slave bus
);
    localparam int c_be_w  = DATA_WIDTH / 8;
    localparam int c_off_w = $clog2(c_be_w);
    localparam logic [2:0] c_max_size = 3'(c_off_w);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_err_0  = 2'd2;
    localparam logic [1:0] c_st_err_1  = 2'd3;

    localparam logic [1:0] c_trans_idle   = 2'd0;
    localparam logic [1:0] c_trans_nonseq = 2'd2;
    localparam logic [1:0] c_trans_seq    = 2'd3;
    localparam logic [2:0] c_burst_single = 3'd0;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
            $error("srdl2sv_ahblite_burst: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    // Beat count of fixed-length bursts, 0 for SINGLE/INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] hb);
        case (hb)
            3'd2, 3'd3: burst_len = 5'd4;
            3'd4, 3'd5: burst_len = 5'd8;
            3'd6, 3'd7: burst_len = 5'd16;
            default:    burst_len = 5'd0;
        endcase
    endfunction

    // WRAP bursts have even non-zero HBURST codes.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            sz,
        input logic [2:0]            hb
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] m;
        inc = a + (ADDR_WIDTH'(1) << sz);
        m   = (ADDR_WIDTH'(burst_len(hb)) << sz) - ADDR_WIDTH'(1);
        if (!hb[0] && (hb != 3'd0))
            next_addr = (a & ~m) | (inc & m);
        else
            next_addr = inc;
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [1:0]            w_phase_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic                  r_burst_act;
    logic [ADDR_WIDTH-1:0] r_exp_addr;
    logic                  r_burst_write;
    logic [2:0]            r_burst_size;
    logic [2:0]            r_burst_type;
    logic [4:0]            r_beats_left;
    logic                  w_burst_fixed;
    logic                  w_sample;
    logic                  w_phase;
    logic                  w_valid;
    logic                  w_addr_err;
    logic                  w_seq_err;
    logic                  w_rsp_err;
    logic [ADDR_WIDTH-1:0] w_align_mask;
    logic [c_be_w-1:0]     w_size_mask;
    logic                  w_unused;

    assign w_unused = ^{bus.HPROT, bus.HMASTLOCK};

    // The address phase is only evaluated in states that complete a data
    // phase this cycle; during wait/first-error cycles HREADY is low anyway.
    assign w_sample = (r_state == c_st_idle) || (r_state == c_st_err_1) ||
                      ((r_state == c_st_access) && bus.r2b_rdy && !bus.r2b_err);
    assign w_phase  = bus.HSEL && bus.HREADY && w_sample;
    assign w_valid  = w_phase && bus.HTRANS[1];
    assign w_rsp_err = (r_state == c_st_access) && bus.r2b_rdy && bus.r2b_err;

    assign w_burst_fixed = (burst_len(r_burst_type) != 5'd0);
    assign w_align_mask  = (ADDR_WIDTH'(1) << bus.HSIZE) - ADDR_WIDTH'(1);
    assign w_seq_err = (bus.HTRANS == c_trans_seq) &&
                       (!r_burst_act || (bus.HADDR != r_exp_addr) ||
                        (bus.HWRITE != r_burst_write) || (bus.HSIZE != r_burst_size) ||
                        (w_burst_fixed && (r_beats_left == 5'd0)));
    assign w_addr_err = (|(bus.HADDR & w_align_mask)) ||
                        (bus.HSIZE > c_max_size) || w_seq_err;

    assign w_phase_next = !w_valid ? c_st_idle : (w_addr_err ? c_st_err_0 : c_st_access);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle, c_st_err_1: w_next = w_phase_next;
            c_st_access: begin
                if (bus.r2b_rdy)
                    w_next = bus.r2b_err ? c_st_err_1 : w_phase_next;
            end
            c_st_err_0: w_next = c_st_err_1;
            default:    w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= c_st_idle;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_size        <= 3'd0;
            r_burst_act   <= 1'b0;
            r_exp_addr    <= '0;
            r_burst_write <= 1'b0;
            r_burst_size  <= 3'd0;
            r_burst_type  <= 3'd0;
            r_beats_left  <= 5'd0;
        end else begin
            r_state <= w_next;
            if (w_valid) begin
                r_addr  <= bus.HADDR;
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
            end
            if (w_rsp_err) begin
                r_burst_act <= 1'b0;
            end else if (w_phase) begin
                if (w_valid && w_addr_err) begin
                    r_burst_act <= 1'b0;
                end else if (bus.HTRANS == c_trans_nonseq) begin
                    r_burst_act   <= (bus.HBURST != c_burst_single);
                    r_burst_write <= bus.HWRITE;
                    r_burst_size  <= bus.HSIZE;
                    r_burst_type  <= bus.HBURST;
                    r_exp_addr    <= next_addr(bus.HADDR, bus.HSIZE, bus.HBURST);
                    r_beats_left  <= burst_len(bus.HBURST) - 5'd1;
                end else if (bus.HTRANS == c_trans_seq) begin
                    r_exp_addr <= next_addr(bus.HADDR, r_burst_size, r_burst_type);
                    if (w_burst_fixed) begin
                        r_beats_left <= r_beats_left - 5'd1;
                        if (r_beats_left == 5'd1)
                            r_burst_act <= 1'b0;
                    end
                end else if (bus.HTRANS == c_trans_idle) begin
                    r_burst_act <= 1'b0;
                end
                // BUSY leaves the burst context untouched.
            end
        end
    end

    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
        bus.b2r_w_vld = 1'b0;
        bus.b2r_r_vld = 1'b0;
        case (r_state)
            c_st_access: begin
                bus.b2r_w_vld = r_write;
                bus.b2r_r_vld = !r_write;
                bus.HREADYOUT = bus.r2b_rdy && !bus.r2b_err;
                bus.HRESP     = bus.r2b_rdy && bus.r2b_err;
                bus.HRDATA    = bus.r2b_data;
            end
            c_st_err_0: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            c_st_err_1: begin
                bus.HRESP = 1'b1;
            end
            default: ;
        endcase
    end

    // Lane mask of 1<<size bytes, shifted to the byte offset within the bus.
    always_comb begin
        w_size_mask = '0;
        for (int i = 0; i < c_be_w; i++)
            w_size_mask[i] = (i < (1 << r_size));
    end

    assign bus.b2r_byte_en = w_size_mask << r_addr[c_off_w-1:0];
    assign bus.b2r_addr    = r_addr;
    assign bus.b2r_data    = bus.HWDATA;

endmodule
`default_nettype wire

// File: tb/tb_srdl2sv_ahblite_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_srdl2sv_ahblite_burst
// Description : Self-checking bench for srdl2sv_ahblite_burst. Expected
//               register accesses are queued when the address phase is driven
//               and compared when the bridge completes the strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srdl2sv_ahblite_burst;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [31:0] wa [5];

    srdl2sv_ahblite_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    srdl2sv_ahblite_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    function automatic logic [31:0] rpat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Single-slave system: HREADY is this slave's own HREADYOUT.
    assign bus.HREADY   = bus.HREADYOUT;
    assign bus.r2b_data = rpat(bus.b2r_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic ap(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [2:0] hb);
        bus.HSEL   = 1'b1;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HBURST = hb;
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
        exp_t e;
        e.write = wr; e.addr = a; e.be = be; e.data = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input string tag, input logic rdy, input logic rs);
        @(negedge clk);
        chk({tag, "_hreadyout"}, bus.HREADYOUT, rdy);
        chk({tag, "_hresp"}, bus.HRESP, rs);
    endtask

    // Called in the cycle after an erroneous address phase was sampled.
    task automatic expect_err(input string tag);
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        resp({tag, "_err0"}, 1'b0, 1'b1);
        chk({tag, "_err0_stb"}, {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
        step();
        resp({tag, "_err1"}, 1'b1, 1'b1);
        chk({tag, "_err1_stb"}, {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
        step();
    endtask

    // Scoreboard: every completed strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.b2r_w_vld || bus.b2r_r_vld) && bus.r2b_rdy) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_strobe", {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_w_vld", bus.b2r_w_vld, e.write);
                chk("sb_r_vld", bus.b2r_r_vld, !e.write);
                chk("sb_addr", bus.b2r_addr, e.addr);
                chk("sb_byte_en", bus.b2r_byte_en, e.be);
                if (e.write) chk("sb_wdata", bus.b2r_data, e.data);
                else         chk("sb_rdata", bus.HRDATA, e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        wa = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h38};
        bus.HSEL = 1'b0; bus.HTRANS = T_IDLE; bus.HWRITE = 1'b0; bus.HADDR = '0;
        bus.HSIZE = 3'd0; bus.HBURST = B_SINGLE; bus.HPROT = 4'h3; bus.HMASTLOCK = 1'b0;
        bus.HWDATA = '0; bus.r2b_rdy = 1'b1; bus.r2b_err = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_hreadyout", bus.HREADYOUT, 1'b1);
        chk("rst_hresp", bus.HRESP, 1'b0);
        chk("rst_strobes", {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_b2r_addr", bus.b2r_addr, 32'h0);
        #19 rst_n = 1'b1;
        step();

        // Single word write, zero wait.
        ap(T_NSEQ, 1'b1, 32'h10, 3'd2, B_SINGLE);
        push(1'b1, 32'h10, 4'hF, 32'hCAFE_0010);
        resp("t1_addr", 1'b1, 1'b0);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.HWDATA = 32'hCAFE_0010;
        resp("t1_data", 1'b1, 1'b0);
        step();
        resp("t1_idle", 1'b1, 1'b0);
        chk("t1_w_vld_drop", bus.b2r_w_vld, 1'b0);
        chk("t1_hrdata_idle", bus.HRDATA, 32'h0);
        step();

        // Byte write at an odd lane.
        ap(T_NSEQ, 1'b1, 32'h13, 3'd0, B_SINGLE);
        push(1'b1, 32'h13, 4'h8, 32'h1122_3344);
        resp("t1b_addr", 1'b1, 1'b0);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.HWDATA = 32'h1122_3344;
        resp("t1b_data", 1'b1, 1'b0);
        step();

        // Halfword read with three wait states.
        ap(T_NSEQ, 1'b0, 32'h08, 3'd1, B_SINGLE);
        push(1'b0, 32'h08, 4'h3, rpat(32'h08));
        resp("t2_addr", 1'b1, 1'b0);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.r2b_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp("t2_wait", 1'b0, 1'b0);
            chk("t2_r_vld_held", bus.b2r_r_vld, 1'b1);
            chk("t2_byte_en", bus.b2r_byte_en, 4'h3);
            step();
        end
        bus.r2b_rdy = 1'b1;
        resp("t2_done", 1'b1, 1'b0);
        step();

        // WRAP4 at 0x38, then an extra SEQ past the last beat.
        for (int i = 0; i < 5; i++) begin
            ap((i == 0) ? T_NSEQ : T_SEQ, 1'b0, wa[i], 3'd2, B_WRAP4);
            if (i < 4) push(1'b0, wa[i], 4'hF, rpat(wa[i]));
            resp("t3_beat", 1'b1, 1'b0);
            step();
        end
        expect_err("t3_fifth_seq");

        // Misaligned word.
        ap(T_NSEQ, 1'b1, 32'h02, 3'd2, B_SINGLE);
        resp("t4_addr", 1'b1, 1'b0);
        step();
        expect_err("t4_misaligned");

        // Doubleword on a 32-bit bus.
        ap(T_NSEQ, 1'b0, 32'h00, 3'd3, B_SINGLE);
        resp("t4b_addr", 1'b1, 1'b0);
        step();
        expect_err("t4b_oversize");

        // INCR with BUSY, register error on beat 2, SEQ afterwards rejected.
        ap(T_NSEQ, 1'b1, 32'h100, 3'd2, B_INCR);
        push(1'b1, 32'h100, 4'hF, 32'hA000_0001);
        resp("t5_b1_addr", 1'b1, 1'b0);
        step();
        ap(T_BUSY, 1'b1, 32'h104, 3'd2, B_INCR);
        bus.HWDATA = 32'hA000_0001;
        resp("t5_b1_data", 1'b1, 1'b0);
        step();
        ap(T_SEQ, 1'b1, 32'h104, 3'd2, B_INCR);
        bus.HWDATA = 32'h0;
        push(1'b1, 32'h104, 4'hF, 32'hA000_0002);
        resp("t5_busy", 1'b1, 1'b0);
        chk("t5_busy_stb", {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.HWDATA = 32'hA000_0002;
        bus.r2b_err = 1'b1;
        resp("t5_rsp_err0", 1'b0, 1'b1);
        step();
        bus.r2b_err = 1'b0;
        ap(T_SEQ, 1'b1, 32'h108, 3'd2, B_INCR);
        resp("t5_rsp_err1", 1'b1, 1'b1);
        step();
        expect_err("t5_ctx_cleared");

        // INCR4 with a SEQ at the wrong address.
        ap(T_NSEQ, 1'b0, 32'h200, 3'd2, B_INCR4);
        push(1'b0, 32'h200, 4'hF, rpat(32'h200));
        resp("t6_addr", 1'b1, 1'b0);
        step();
        ap(T_SEQ, 1'b0, 32'h208, 3'd2, B_INCR4);
        resp("t6_b0", 1'b1, 1'b0);
        step();
        expect_err("t6_mismatch");

        // Reset asserted during a wait state.
        ap(T_NSEQ, 1'b0, 32'h20, 3'd2, B_SINGLE);
        resp("t7_addr", 1'b1, 1'b0);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.r2b_rdy = 1'b0;
        @(negedge clk);
        chk("t7_wait_r_vld", bus.b2r_r_vld, 1'b1);
        chk("t7_wait_hreadyout", bus.HREADYOUT, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_strobes", {bus.b2r_w_vld, bus.b2r_r_vld}, 2'b00);
        chk("t7_rst_hreadyout", bus.HREADYOUT, 1'b1);
        chk("t7_rst_hresp", bus.HRESP, 1'b0);
        chk("t7_rst_hrdata", bus.HRDATA, 32'h0);
        bus.r2b_rdy = 1'b1;
        step();
        #3 rst_n = 1'b1;
        step();
        ap(T_NSEQ, 1'b1, 32'h24, 3'd2, B_SINGLE);
        push(1'b1, 32'h24, 4'hF, 32'h7777_0024);
        resp("t7_post_addr", 1'b1, 1'b0);
        step();
        ap(T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        bus.HWDATA = 32'h7777_0024;
        resp("t7_post_data", 1'b1, 1'b0);
        step();

        resp("end_idle", 1'b1, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/srdl2sv_ahblite_burst.md
SRDL2SV_AHBLITE_BURST -- requirements
Module: srdl2sv_ahblite_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 32, meaning bus/register data width; SHALL accept only 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, meaning HADDR and b2r_addr width.
REQ-003 HCLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 HSEL, HWRITE, HREADY, HMASTLOCK  input  1 each  AHB-Lite controls; HMASTLOCK SHALL be ignored.
REQ-006 HADDR  input  ADDR_WIDTH, and HSIZE/HBURST  input  3 each, and HPROT  input  4, and HTRANS  input  2; HPROT SHALL be ignored.
REQ-007 HWDATA  input  DATA_WIDTH  write data, valid in data phase.
REQ-008 HREADYOUT, HRESP  output  1 each, and HRDATA  output  DATA_WIDTH  AHB-Lite slave response.
REQ-009 b2r_w_vld, b2r_r_vld  output  1 each  register write/read strobe, held until r2b_rdy.
REQ-010 b2r_addr  output  ADDR_WIDTH; b2r_data  output  DATA_WIDTH; b2r_byte_en  output  DATA_WIDTH/8.
REQ-011 r2b_rdy, r2b_err  input  1 each; r2b_data  input  DATA_WIDTH  register-side response.

Function
REQ-012 Address phase valid SHALL mean HSEL && HREADY && HTRANS in {NONSEQ, SEQ}; only then SHALL HADDR/HWRITE/HSIZE/HBURST be captured.
REQ-013 Address-phase error SHALL be flagged for: HADDR not aligned to 1<<HSIZE; (1<<HSIZE) > DATA_WIDTH/8; SEQ without an active burst; SEQ whose HADDR/HWRITE/HSIZE differ from the expected beat; SEQ beyond the beat count of a fixed-length burst (4/8/16).
REQ-014 FSM states IDLE, ACCESS, ERR_0, ERR_1.
REQ-015 IDLE: HREADYOUT=1, HRESP=0; valid phase without error -> ACCESS; with error -> ERR_0; else stay.
REQ-016 ACCESS: b2r_w_vld = captured write, b2r_r_vld = captured read; HREADYOUT = r2b_rdy && !r2b_err; HRESP = r2b_rdy && r2b_err.
REQ-017 ACCESS with r2b_rdy && r2b_err SHALL -> ERR_1; with r2b_rdy && !r2b_err, next state SHALL follow REQ-015 rules on the concurrent address phase; without r2b_rdy SHALL stay (wait state).
REQ-018 ERR_0: HREADYOUT=0, HRESP=1, no strobe -> ERR_1. ERR_1: HREADYOUT=1, HRESP=1 and SHALL sample the concurrent address phase per REQ-015.
REQ-019 BUSY or IDLE HTRANS SHALL receive a zero-wait OKAY and never strobe b2r; BUSY SHALL retain burst context.
REQ-020 Expected next address: INCR-type = addr + (1<<HSIZE); WRAPn = (addr & ~M) | ((addr + (1<<HSIZE)) & M), M = n*(1<<HSIZE)-1.
REQ-021 Burst context SHALL start on error-free NONSEQ with HBURST != SINGLE and clear on IDLE HTRANS, NONSEQ SINGLE, any error, or last beat of a fixed burst.
REQ-022 b2r_byte_en SHALL be ((1<<(1<<HSIZE))-1) << (addr mod DATA_WIDTH/8), from captured values.
REQ-023 b2r_data SHALL equal HWDATA combinationally; b2r_addr SHALL equal captured address.
REQ-024 HRDATA SHALL equal r2b_data in ACCESS, else all zeros.

Reset
REQ-025 On HRESETn low: FSM -> IDLE, burst context cleared, b2r_w_vld=b2r_r_vld=0, HREADYOUT=1, HRESP=0, HRDATA=0, captured address/controls=0, asynchronously, including mid-burst or mid-wait.

Verification
REQ-026 Single write HADDR=0x10, HSIZE=2, r2b_rdy=1 -> b2r_w_vld one cycle, b2r_addr=0x10, b2r_byte_en=0xF (32b), OKAY zero-wait.
REQ-027 Read 0x08 HSIZE=1 with r2b_rdy low 3 cycles -> HREADYOUT=0 three cycles, b2r_r_vld held, byte_en=0x3, HRDATA=r2b_data on the ready cycle.
REQ-028 WRAP4 HSIZE=2 at 0x38 -> beats 0x38,0x3C,0x30,0x34 accepted; fifth SEQ -> ERROR response, no strobe.
REQ-029 HADDR=0x02 HSIZE=2 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, no b2r strobe.
REQ-030 INCR burst with BUSY between beats and r2b_err on beat 2 -> BUSY zero-wait OKAY, beat 2 two-cycle ERROR, context cleared.
REQ-031 HRESETn asserted during ACCESS wait state -> strobes drop immediately, HREADYOUT=1, next NONSEQ accepted normally.
